// File: rtl/party_seed_gen_pkg.sv
// party_seed_gen_pkg: shared state encoding, widths and KDF constants for the party seed generator.
package party_seed_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HASH = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int IDX_W     = 8;
    localparam int KDF_PAD_W = 112;

    // Odd multiplier keeps every 128-bit input word influencing the result.
    localparam logic [127:0] KDF_MULT   = 128'h9E3779B97F4A7C15F39CC0605CEDC835;
    localparam logic [2:0]   KDF_ROUNDS = 3'd4;

endpackage

// File: rtl/party_seed_gen_kdf.sv
// KDF_for_party_seed: multi-cycle KDF core; absorbs the 512-bit input as four 128-bit words.
// Ports: clk, reset (async active-low), Hstart (level request, launches on its rising edge),
//        restart (abort), din[511:0], dout[1023:0] (stable from en_end until next launch),
//        en_end (1-cycle completion pulse).
module KDF_for_party_seed
    import party_seed_gen_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          Hstart,
    input  logic          restart,
    input  logic [511:0]  din,
    output logic [1023:0] dout,
    output logic          en_end
);

    logic          r_hs_q;
    logic          r_busy;
    logic [2:0]    r_cnt;
    logic [511:0]  r_din;
    logic [127:0]  r_acc;
    logic [1023:0] r_dout;
    logic          r_end;

    // Hstart is held high by the requester until en_end, so only its rising edge launches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hs_q <= 1'b0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_din  <= '0;
            r_acc  <= '0;
            r_dout <= '0;
            r_end  <= 1'b0;
        end else begin
            r_hs_q <= Hstart;
            r_end  <= 1'b0;
            if (restart) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (!r_busy) begin
                if (Hstart & ~r_hs_q) begin
                    r_busy <= 1'b1;
                    r_cnt  <= '0;
                    r_din  <= din;
                    r_acc  <= '0;
                end
            end else if (r_cnt == KDF_ROUNDS) begin
                r_busy <= 1'b0;
                r_end  <= 1'b1;
                r_dout <= {r_acc, ~r_acc, {6{r_acc ^ KDF_MULT}}};
            end else begin
                // Horner step over the words, most significant word first.
                r_acc <= r_acc * KDF_MULT + r_din[511:384];
                r_din <= r_din << 128;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout   = r_dout;
    assign en_end = r_end;

endmodule

// File: rtl/party_seed_gen.sv
// party_seed_gen: streams one KDF-derived 128-bit seed per (repetition, party) pair.
// Ports: i_clk, i_reset (async active-low), i_start (level request, sampled in IDLE),
//        i_root_seed/i_salt (captured on the start cycle), o_seed_out/o_seed_rep/o_seed_party
//        with o_seed_valid and i_seed_ready handshake, o_gen_end (held until i_start low).
module party_seed_gen
    import party_seed_gen_pkg::*;
#(
    parameter int NUM_REPS    = 4,
    parameter int NUM_PARTIES = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [127:0] i_root_seed,
    input  logic [255:0] i_salt,
    output logic [127:0] o_seed_out,
    output logic [7:0]   o_seed_rep,
    output logic [7:0]   o_seed_party,
    output logic         o_seed_valid,
    input  logic         i_seed_ready,
    output logic         o_gen_end
);

    state_t              r_state;
    state_t              w_next;
    logic [127:0]        r_root_seed;
    logic [255:0]        r_salt;
    logic [IDX_W-1:0]    r_rep_idx;
    logic [IDX_W-1:0]    r_party_idx;
    logic [127:0]        r_seed_out;
    logic [IDX_W-1:0]    r_seed_rep;
    logic [IDX_W-1:0]    r_seed_party;
    logic                r_seed_valid;
    logic                r_gen_end;

    logic                w_start_ok;
    logic                w_hs;
    logic                w_last_party;
    logic                w_last;
    logic                w_seed_cap;
    logic                w_kdf_start;
    logic                w_kdf_end;
    logic [511:0]        w_kdf_din;
    logic [1023:0]       w_kdf_dout;
    logic                w_unused_dout;

    assign w_start_ok   = (r_state == S_IDLE) & i_start & ~r_gen_end;
    assign w_hs         = (r_state == S_OUT) & r_seed_valid & i_seed_ready;
    assign w_last_party = r_party_idx == IDX_W'(NUM_PARTIES - 1);
    assign w_last       = w_last_party & (r_rep_idx == IDX_W'(NUM_REPS - 1));
    // A kdf_end outside WAIT is ignored.
    assign w_seed_cap   = (r_state == S_WAIT) & w_kdf_end;
    assign w_kdf_start  = (r_state == S_HASH) | (r_state == S_WAIT);
    assign w_kdf_din    = {r_root_seed, r_salt, r_rep_idx, r_party_idx, {KDF_PAD_W{1'b0}}};
    assign w_unused_dout = ^w_kdf_dout[895:0];

    KDF_for_party_seed u_kdf (
        .clk     (i_clk),
        .reset   (i_reset),
        .Hstart  (w_kdf_start),
        .restart (1'b0),
        .din     (w_kdf_din),
        .dout    (w_kdf_dout),
        .en_end  (w_kdf_end)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start_ok ? S_HASH : S_IDLE;
            S_HASH:  w_next = S_WAIT;
            S_WAIT:  w_next = w_kdf_end ? S_OUT : S_WAIT;
            S_OUT:   w_next = w_hs ? (w_last ? S_DONE : S_HASH) : S_OUT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_root_seed  <= '0;
            r_salt       <= '0;
            r_rep_idx    <= '0;
            r_party_idx  <= '0;
            r_seed_out   <= '0;
            r_seed_rep   <= '0;
            r_seed_party <= '0;
            r_seed_valid <= 1'b0;
            r_gen_end    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_root_seed <= i_root_seed;
                r_salt      <= i_salt;
                r_rep_idx   <= '0;
                r_party_idx <= '0;
            end
            if (w_seed_cap) begin
                r_seed_out   <= w_kdf_dout[1023:896];
                r_seed_rep   <= r_rep_idx;
                r_seed_party <= r_party_idx;
                r_seed_valid <= 1'b1;
            end
            if (w_hs) begin
                r_seed_valid <= 1'b0;
                r_party_idx  <= w_last_party ? '0 : r_party_idx + 1'b1;
                r_rep_idx    <= w_last_party ? r_rep_idx + 1'b1 : r_rep_idx;
            end
            // DONE raises gen_end; afterwards it survives only while start stays high.
            r_gen_end <= (r_state == S_DONE) | (r_gen_end & i_start);
        end
    end

    assign o_seed_out   = r_seed_out;
    assign o_seed_rep   = r_seed_rep;
    assign o_seed_party = r_seed_party;
    assign o_seed_valid = r_seed_valid;
    assign o_gen_end    = r_gen_end;

endmodule

// File: doc/party_seed_gen.md
# party_seed_gen

Derives the per-repetition, per-party 128-bit seeds from the root seed and salt. It sits directly downstream of the seed/salt setup stage. It consumes that stage's `root_seed` and `salt` once the setup stage signals completion, and streams one seed per (repetition, party) pair to the tape-generation stage over a valid/ready handshake. Every seed is produced by one pass through a dedicated KDF core instance.

## Interface
- `NUM_REPS`, 4: repetitions per signature; range 1..255.
- `NUM_PARTIES`, 3: parties per repetition; range 1..255.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: level request; sampled only in IDLE.
- `root_seed` input 128: captured on the start cycle.
- `salt` input 256: captured on the start cycle.
- `seed_out` output 128: current party seed.
- `seed_rep` output 8: repetition index of `seed_out`.
- `seed_party` output 8: party index of `seed_out`.
- `seed_valid` output 1: `seed_out`, `seed_rep` and `seed_party` are valid.
- `seed_ready` input 1: the consumer accepts the seed when `seed_valid & seed_ready`.
- `gen_end` output 1: all seeds delivered. Held high until `start` is low.

## Operation
- Reset values: `seed_out`=0, `seed_rep`=0, `seed_party`=0, `seed_valid`=0, `gen_end`=0, state IDLE, counters 0, KDF start low.
- **IDLE**
  - On `start & ~gen_end`: latch `root_seed` and `salt`, clear `rep_idx` and `party_idx`, go to HASH.
  - `start` high while `gen_end` is high does not retrigger.
- **HASH**
  - Drive KDF input: `{root_seed, salt, rep_idx[7:0], party_idx[7:0], 112'h0}` (512 bits).
  - Assert `kdf_start`, keep `kdf_restart` low, go to WAIT.
- **WAIT**
  - Hold `kdf_start` high until `kdf_end`.
  - On `kdf_end`:
    - Register `seed_out` = `kdf_dout[1023:896]`.
    - Set `seed_rep` and `seed_party` to the current indices.
    - Drop `kdf_start`, assert `seed_valid`, go to OUT.
- **OUT**
  - Hold all seed outputs stable while `seed_valid & ~seed_ready`.
  - On handshake, deassert `seed_valid` and advance the indices:
    - If `party_idx == NUM_PARTIES-1`: set `party_idx`=0 and increment `rep_idx`; otherwise increment `party_idx`.
    - If the accepted seed was the last pair (`NUM_REPS-1`, `NUM_PARTIES-1`), go to DONE; otherwise go to HASH.
- **DONE**
  - Set `gen_end`=1 and return to IDLE.
  - `gen_end` clears on the first cycle `start` is low. This is checked in every state.
- `start` falling mid-operation is ignored; the sequence runs to completion.
- Latched `root_seed` and `salt` are immune to input changes after the start cycle.
- Total seeds per run: exactly `NUM_REPS*NUM_PARTIES`, in rep-major, party-minor order.

## Timing
- Start to first KDF request: 2 cycles (IDLE→HASH→WAIT).
- `kdf_end` to `seed_valid`: 1 cycle (registered).
- Handshake to next `kdf_start`: 2 cycles (OUT→HASH→WAIT).
- Seed period is therefore KDF latency + 3 cycles when `seed_ready` is tied high.
- Last handshake to `gen_end` high: 2 cycles.
- `seed_valid` never drops without a handshake, and the outputs never change while valid is high and ready is low.
- A `kdf_end` pulse outside WAIT is ignored.
- Reset low at any cycle:
  - Returns immediately to reset values, with no spurious `seed_valid` or `gen_end`.
  - The KDF core is reset through the same `reset` port.

## Structure
- Shared package holds:
  - State encoding: IDLE, HASH, WAIT, OUT, DONE as 3-bit constants.
  - KDF input pad width (112).
  - Index width (8).
- One sub-module: `KDF_for_party_seed`. It is the same core family already used for seed/salt derivation, with ports `(clk, reset, Hstart, restart, din[511:0], dout[1023:0], en_end)`.
  - `en_end` is a 1-cycle pulse.
  - `dout` is stable from `en_end` until the next `Hstart`.
- The FSM, counters and output registers live in `party_seed_gen`.

## Test plan
- **Basic run.** `NUM_REPS`=2, `NUM_PARTIES`=3, `seed_ready` tied 1, KDF model latency 5 → exactly 6 `seed_valid` pulses with (rep, party) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). Each `seed_out` equals model `dout[1023:896]` for the matching din. `gen_end` rises 2 cycles after the 6th handshake.
- **Backpressure.** Hold `seed_ready` low for 10 cycles on seed (0,1) → outputs constant for all 10 cycles. No KDF request is issued until acceptance.
- **Input capture.** Change `root_seed` and `salt` 1 cycle after start → all seeds match the values captured on the start cycle.
- **Level start.** Keep `start` high after `gen_end` → no second run. Drop `start` → `gen_end` clears next cycle. Raise `start` again → a new run of 6 seeds.
- **Reset mid-run.** Assert `reset` low while in WAIT for seed (1,0) → all outputs 0 and state IDLE on the same edge. After release with `start` high, the sequence restarts at (0,0).
- **Stray KDF pulse.** Inject `kdf_end` while in OUT → no output change and no extra seed.
